// File: rtl/step_sequencer.sv
// Step sequencer: for each integration step it runs the update module and the collision detector,
// and on a collision the velocity selector. It writes one result per step and stops after NUM_STEPS.
module step_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] vx_in,
    input  logic [15:0] vy_in,
    output logic        um_in_rdy,
    input  logic        um_out_rdy,
    input  logic [15:0] xnew,
    input  logic [15:0] ynew,
    input  logic [15:0] vxnew,
    input  logic [15:0] vynew,
    output logic        cd_in_rdy,
    input  logic        cd_out_rdy,
    input  logic        trial,
    output logic        vs_in_rdy,
    input  logic        vs_out_rdy,
    input  logic [15:0] vs_vxout,
    input  logic [15:0] vs_vyout,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic [15:0] vel_x,
    output logic [15:0] vel_y,
    output logic        wr_en,
    output logic [15:0] step_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    // One-hot encoding, so that each status output comes directly from a state flop.
    localparam int S_UM = 1, S_CD = 2, S_VS = 3, S_WR = 4, S_DN = 5, S_ER = 6;
    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        UM_RUN = 7'b0000010,
        CD_RUN = 7'b0000100,
        VS_RUN = 7'b0001000,
        WRITE  = 7'b0010000,
        DONE_S = 7'b0100000,
        ERR_S  = 7'b1000000
    } state_t;

    state_t          state;
    logic            um_prev, cd_prev, vs_prev;
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   retry;
    logic            busy_r;

    wire um_rise  = um_out_rdy & ~um_prev;
    wire cd_rise  = cd_out_rdy & ~cd_prev;
    wire vs_rise  = vs_out_rdy & ~vs_prev;
    wire wait_exp = (wait_cnt == WW'(TIMEOUT - 1));

    assign um_in_rdy = state[S_UM];
    assign cd_in_rdy = state[S_CD];
    assign vs_in_rdy = state[S_VS];
    assign wr_en     = state[S_WR];
    assign done      = state[S_DN];
    assign err       = state[S_ER];
    assign busy      = busy_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            um_prev  <= 1'b0;
            cd_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            wait_cnt <= '0;
            retry    <= '0;
            busy_r   <= 1'b0;
            step_cnt <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            vel_x    <= '0;
            vel_y    <= '0;
        end else begin
            // Previous flag values are tracked in every state, so a flag already high on entry is not seen as a rise.
            um_prev <= um_out_rdy;
            cd_prev <= cd_out_rdy;
            vs_prev <= vs_out_rdy;
            case (state)
                IDLE: if (start) begin
                    pos_x    <= x_in;
                    pos_y    <= y_in;
                    vel_x    <= vx_in;
                    vel_y    <= vy_in;
                    step_cnt <= '0;
                    retry    <= '0;
                    wait_cnt <= '0;
                    busy_r   <= 1'b1;
                    state    <= UM_RUN;
                end
                UM_RUN: begin
                    if (um_rise) begin
                        pos_x    <= xnew;
                        pos_y    <= ynew;
                        vel_x    <= vxnew;
                        vel_y    <= vynew;
                        wait_cnt <= '0;
                        state    <= CD_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_exp) begin
                            busy_r <= 1'b0;
                            state  <= ERR_S;
                        end
                    end
                end
                CD_RUN: begin
                    if (cd_rise) begin
                        wait_cnt <= '0;
                        if (trial && (retry < RW'(MAX_RETRY))) begin
                            retry <= retry + 1'b1;
                            state <= VS_RUN;
                        end else begin
                            state <= WRITE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_exp) begin
                            busy_r <= 1'b0;
                            state  <= ERR_S;
                        end
                    end
                end
                VS_RUN: begin
                    if (vs_rise) begin
                        vel_x    <= vs_vxout;
                        vel_y    <= vs_vyout;
                        wait_cnt <= '0;
                        state    <= UM_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_exp) begin
                            busy_r <= 1'b0;
                            state  <= ERR_S;
                        end
                    end
                end
                WRITE: begin
                    step_cnt <= step_cnt + 16'd1;
                    retry    <= '0;
                    wait_cnt <= '0;
                    if (step_cnt + 16'd1 == 16'(NUM_STEPS)) begin
                        busy_r <= 1'b0;
                        state  <= DONE_S;
                    end else begin
                        state  <= UM_RUN;
                    end
                end
                DONE_S: if (!start) state <= IDLE;
                ERR_S:  state <= ERR_S;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: the bench drives the update module, the collision detector
// and the velocity selector by hand and checks against hand-computed values.
module tb_step_sequencer;
    localparam int NS = 4, TO = 255, MR = 3;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, vx_in = '0, vy_in = '0;
    logic        um_out_rdy = 1'b0, cd_out_rdy = 1'b0, vs_out_rdy = 1'b0, trial = 1'b0;
    logic [15:0] xnew = '0, ynew = '0, vxnew = '0, vynew = '0, vs_vxout = '0, vs_vyout = '0;
    logic        um_in_rdy, cd_in_rdy, vs_in_rdy, wr_en, busy, done, err;
    logic [15:0] pos_x, pos_y, vel_x, vel_y, step_cnt;

    int tot = 0, bad = 0;
    int wr_cnt = 0, vs_eps = 0;
    logic vs_d = 1'b0;

    step_sequencer #(.NUM_STEPS(NS), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clock(clock), .reset(reset), .start(start),
        .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
        .um_in_rdy(um_in_rdy), .um_out_rdy(um_out_rdy),
        .xnew(xnew), .ynew(ynew), .vxnew(vxnew), .vynew(vynew),
        .cd_in_rdy(cd_in_rdy), .cd_out_rdy(cd_out_rdy), .trial(trial),
        .vs_in_rdy(vs_in_rdy), .vs_out_rdy(vs_out_rdy),
        .vs_vxout(vs_vxout), .vs_vyout(vs_vyout),
        .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
        .wr_en(wr_en), .step_cnt(step_cnt), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        vs_d <= vs_in_rdy;
        if (vs_in_rdy && !vs_d) vs_eps <= vs_eps + 1;
        if (wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0: return um_in_rdy;
            1: return cd_in_rdy;
            2: return vs_in_rdy;
            3: return wr_en;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag);
        int n = 0;
        while (!sel(w) && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 16'(sel(w)), 16'd1);
    endtask

    task automatic pulse(input int w);
        case (w)
            0: um_out_rdy = 1'b1;
            1: cd_out_rdy = 1'b1;
            default: vs_out_rdy = 1'b1;
        endcase
        @(negedge clock);
        um_out_rdy = 1'b0;
        cd_out_rdy = 1'b0;
        vs_out_rdy = 1'b0;
    endtask

    task automatic um_step(input logic [15:0] a, b, c, d);
        wait_sig(0, "um_rdy");
        xnew = a; ynew = b; vxnew = c; vynew = d;
        pulse(0);
    endtask

    task automatic cd_step(input logic t);
        wait_sig(1, "cd_rdy");
        trial = t;
        pulse(1);
        trial = 1'b0;
    endtask

    task automatic vs_step(input logic [15:0] vx, vy);
        wait_sig(2, "vs_rdy");
        vs_vxout = vx; vs_vyout = vy;
        pulse(2);
    endtask

    task automatic start_run(input logic [15:0] x, y, vx, vy);
        x_in = x; y_in = y; vx_in = vx; vy_in = vy;
        start = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int base;
        logic [15:0] px;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_um", 16'(um_in_rdy), 16'd0);
        chk("rst_pos", pos_x, 16'h0000);
        chk("rst_cnt", step_cnt, 16'd0);
        reset = 1'b0;
        @(negedge clock);

        // a done flag already high on UM entry must be ignored until it falls and rises again
        um_out_rdy = 1'b1;
        @(negedge clock);
        start_run(16'h0100, 16'h0000, 16'h0400, 16'h0200);
        start = 1'b0;
        chk("load_busy", 16'(busy), 16'd1);
        chk("load_um", 16'(um_in_rdy), 16'd1);
        chk("load_px", pos_x, 16'h0100);
        chk("load_vx", vel_x, 16'h0400);
        repeat (3) @(negedge clock);
        chk("held_um", 16'(um_in_rdy), 16'd1);
        chk("held_cd", 16'(cd_in_rdy), 16'd0);
        um_out_rdy = 1'b0;
        @(negedge clock);

        // one collision: VS velocity is used by the UM re-run
        um_step(16'h0200, 16'h0000, 16'h0400, 16'h0200);
        cd_step(1'b1);
        wait_sig(2, "vs1_rdy");
        chk("vs1_cd", 16'(cd_in_rdy), 16'd0);
        vs_step(16'hFC00, 16'h0200);
        wait_sig(0, "rerun_um");
        chk("rerun_vx", vel_x, 16'hFC00);
        chk("rerun_px", pos_x, 16'h0200);
        um_step(16'h0100, 16'h0000, 16'hFC00, 16'h0200);
        cd_step(1'b0);
        wait_sig(3, "wr1");
        chk("wr1_px", pos_x, 16'h0100);
        chk("wr1_vx", vel_x, 16'hFC00);
        @(negedge clock);
        chk("wr1_cnt", step_cnt, 16'd1);

        // persistent collision: MR selector passes, then accepted unresolved (also proves retry cleared)
        @(negedge clock);
        base = vs_eps;
        for (int i = 0; i < MR; i++) begin
            um_step(16'h0100, 16'h0000, 16'h0100, 16'h0100);
            cd_step(1'b1);
            vs_step(16'h0100, 16'h0100);
        end
        um_step(16'h0100, 16'h0000, 16'h0100, 16'h0100);
        cd_step(1'b1);
        wait_sig(3, "wr2");
        chk("wr2_vs", 16'(vs_in_rdy), 16'd0);
        @(negedge clock);
        chk("retry_eps", 16'(vs_eps - base), 16'(MR));
        chk("wr2_cnt", step_cnt, 16'd2);

        // reset while in VS_RUN
        um_step(16'h0300, 16'h0000, 16'h0100, 16'h0100);
        cd_step(1'b1);
        wait_sig(2, "vs3_rdy");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_vs", 16'(vs_in_rdy), 16'd0);
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_px", pos_x, 16'h0000);
        chk("mid_vx", vel_x, 16'h0000);
        chk("mid_cnt", step_cnt, 16'd0);
        @(negedge clock);

        // full normal run of NS steps, start held high throughout
        base = wr_cnt;
        start_run(16'h0800, 16'h0100, 16'h0400, 16'h0000);
        for (int i = 0; i < NS; i++) begin
            px = 16'h0A00 + 16'(i * 16'h0400);
            um_step(px, 16'h0100, 16'h0400, 16'h0000);
            wait_sig(1, "run_cd");
            chk("run_cd_px", pos_x, px);
            cd_step(1'b0);
            wait_sig(3, "run_wr");
            chk("run_wr_px", pos_x, px);
            if (i == 0) begin
                @(negedge clock);
                chk("run_cnt1", step_cnt, 16'd1);
            end
        end
        repeat (2) @(negedge clock);
        chk("run_done", 16'(done), 16'd1);
        chk("run_busy", 16'(busy), 16'd0);
        chk("run_cnt", step_cnt, 16'(NS));
        chk("run_wrs", 16'(wr_cnt - base), 16'(NS));
        repeat (3) @(negedge clock);
        chk("hold_done", 16'(done), 16'd1);
        chk("hold_um", 16'(um_in_rdy), 16'd0);
        start = 1'b0;
        @(negedge clock);
        chk("idle_done", 16'(done), 16'd0);

        // CD never answers -> ERR after TO waiting cycles, frozen until reset
        start_run(16'h1234, 16'h0000, 16'h0000, 16'h0000);
        start = 1'b0;
        um_step(16'h1234, 16'h0000, 16'h0000, 16'h0000);
        repeat (TO - 1) @(negedge clock);
        chk("to_pre_err", 16'(err), 16'd0);
        chk("to_pre_cd", 16'(cd_in_rdy), 16'd1);
        @(negedge clock);
        chk("to_err", 16'(err), 16'd1);
        chk("to_cd", 16'(cd_in_rdy), 16'd0);
        chk("to_busy", 16'(busy), 16'd0);
        start = 1'b1;
        pulse(1);
        repeat (4) @(negedge clock);
        chk("err_stuck", 16'(err), 16'd1);
        chk("err_um", 16'(um_in_rdy), 16'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("err_clr", 16'(err), 16'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
